pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic elastic pipeline stage register for the RV32I core. It carries a parametrised payload between two pipeline stages with a valid/ready handshake, flush, and exception-kill handling. A killed or flushed entry turns into a bubble whose masked fields keep their payload, so the trap logic still sees the instruction address. It is the parametrised successor of the fixed per-stage registers and is instantiated between IF/ID, ID/EX and EX/MEM.

## Interface
Parameters:
- DATA_W, 128 — payload width in bits (≥1).
- BUBBLE_VALUE, 128'h13 (INST_NOP in bits [31:0], zero elsewhere), width DATA_W — value forced into non-kept bits on kill, flush and reset.
- KEEP_MASK, 0, width DATA_W — bit=1: the field keeps its payload on kill and holds its value on flush.
- CNT_W, 8 — width of the kill counter.

Ports (one clock `clk`; reset `rst_sync` is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst_sync  in  1  synchronous active-high reset.
- flush  in  1  discard the held entry, and any entry in transfer, this cycle.
- up_valid  in  1  upstream offers an entry.
- up_ready  out  1  stage can accept an entry.
- up_data  in  DATA_W  upstream payload.
- up_kill  in  1  upstream entry raised an exception; accept it as a bubble.
- dn_valid  out  1  entry presented downstream.
- dn_ready  in  1  downstream consumes the entry.
- dn_data  out  DATA_W  payload presented downstream.
- dn_killed  out  1  presented entry is a killed bubble.
- kill_count  out  CNT_W  saturating count of accepted killed entries.

## Operation
- Transfer in: `up_valid && up_ready`. Transfer out: `dn_valid && dn_ready`.
- Bubble function B(x) = (x & KEEP_MASK) | (BUBBLE_VALUE & ~KEEP_MASK).
- Accept, no flush: dn_valid←1, dn_data←(up_kill ? B(up_data) : up_data), dn_killed←up_kill.
- Accept with up_kill: kill_count←kill_count+1, saturating at 2^CNT_W−1.
- No accept, transfer out: dn_valid←0 and dn_killed←0. dn_data holds.
- No accept, no transfer out: all outputs hold (stall).
- up_kill is ignored unless up_valid is high.
- Priority, highest first:
  - rst_sync: dn_valid=0, dn_killed=0, dn_data=BUBBLE_VALUE (all bits, kept bits included), kill_count=0.
  - flush: dn_valid←0 and dn_killed←0. Non-kept dn_data bits←BUBBLE_VALUE; kept bits hold. An upstream transfer in the same cycle is discarded and is not counted. kill_count holds.
  - Normal accept / drain / stall as above.
- A killed entry is still delivered with dn_valid=1 so downstream trap logic can sample its kept fields.

## Timing
- Latency 1 cycle from transfer in to dn_valid; throughput 1 entry/cycle under continuous dn_ready.
- Base mode: up_ready = !dn_valid || dn_ready (combinational path from dn_ready). It does not depend on flush.
- dn_valid, once high, holds with dn_data stable until a transfer out, flush or reset.
- Reset or flush in cycle N: dn_valid=0 from cycle N+1; up_ready=1 from cycle N+1.
- A reset asserted mid-stall discards the entry; nothing is replayed.

## Configuration
- PIPE_STAGE_SKID_EN defined: adds a one-entry skid buffer.
  - up_ready = !skid_valid, a registered signal with no combinational path from dn_ready.
  - Accept while dn_valid && !dn_ready: the entry, already bubbled if killed, goes to the skid buffer.
  - Transfer out while skid_valid: the skid entry moves to the output and skid_valid←0 in the same edge.
  - Flush and reset clear skid_valid. Ordering is preserved and latency is unchanged.
- Undefined: no skid buffer; base-mode up_ready equation applies.

## Test plan
- Reset with DATA_W=128 defaults → dn_valid=0, dn_killed=0, dn_data=128'h13, kill_count=0, up_ready=1.
- Stream 0x1..0x5 with dn_ready=1 → dn_data 0x1..0x5 on consecutive cycles, each one cycle after its up_valid, with no gaps.
- KEEP_MASK=0xFFFF_FFFF<<32; send up_data={64'h0, 32'h8000_0040, 32'h0000_0033} with up_kill=1 → dn_data={64'h0, 32'h8000_0040, 32'h13}, dn_killed=1, kill_count=1.
- Hold dn_ready=0 with the entry 0xAB held and up_valid=1 carrying 0xCD → base mode: up_ready=0 and dn_data stays 0xAB. Skid mode: 0xCD is accepted, up_ready goes 0 next cycle, and releasing dn_ready delivers 0xAB then 0xCD.
- Flush in the same cycle as an accept of 0x77, with dn_valid=1 holding 0x55 → next cycle dn_valid=0, kept bits still 0x55's, 0x77 never appears downstream.
- 300 consecutive killed accepts with CNT_W=8 → kill_count saturates at 255 and stays there.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with flush, kill-to-bubble and kill counter; PIPE_STAGE_SKID_EN adds a one-entry skid buffer
module pipe_stage_reg #(
    parameter int unsigned       DATA_W       = 128,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = DATA_W'(128'h13),
    parameter logic [DATA_W-1:0] KEEP_MASK    = '0,
    parameter int unsigned       CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_sync,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_kill,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic              dn_killed,
    output logic [CNT_W-1:0]  kill_count
);
    function automatic logic [DATA_W-1:0] bubble(input logic [DATA_W-1:0] x);
        return (x & KEEP_MASK) | (BUBBLE_VALUE & ~KEEP_MASK);
    endfunction

    logic              valid_q, valid_d, killed_q, killed_d;
    logic [DATA_W-1:0] data_q, data_d, in_data;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc, xfer;
`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d, skid_killed_q, skid_killed_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    assign up_ready = !skid_valid_q;
`else
    assign up_ready = !valid_q || dn_ready;
`endif
    assign acc        = up_valid && up_ready;
    assign xfer       = valid_q && dn_ready;
    assign in_data    = up_kill ? bubble(up_data) : up_data;
    assign dn_valid   = valid_q;
    assign dn_data    = data_q;
    assign dn_killed  = killed_q;
    assign kill_count = cnt_q;

    // next-state: flush beats accept; otherwise accept, drain or stall
    always_comb begin
        valid_d  = valid_q;
        killed_d = killed_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_valid_d  = skid_valid_q;
        skid_killed_d = skid_killed_q;
        skid_data_d   = skid_data_q;
`endif
        if (flush) begin
            valid_d  = 1'b0;
            killed_d = 1'b0;
            data_d   = bubble(data_q);
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end else begin
            if (acc && up_kill)
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef PIPE_STAGE_SKID_EN
            if (!valid_q || xfer) begin
                if (skid_valid_q) begin
                    valid_d      = 1'b1;
                    data_d       = skid_data_q;
                    killed_d     = skid_killed_q;
                    skid_valid_d = 1'b0;
                end else begin
                    valid_d  = acc;
                    killed_d = acc && up_kill;
                    data_d   = acc ? in_data : data_q;
                end
            end else if (acc) begin
                skid_valid_d  = 1'b1;
                skid_data_d   = in_data;
                skid_killed_d = up_kill;
            end
`else
            if (acc) begin
                valid_d  = 1'b1;
                data_d   = in_data;
                killed_d = up_kill;
            end else if (xfer) begin
                valid_d  = 1'b0;
                killed_d = 1'b0;
            end
`endif
        end
    end

    // state registers with synchronous reset to an empty bubble
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            valid_q  <= 1'b0;
            killed_q <= 1'b0;
            data_q   <= BUBBLE_VALUE;
            cnt_q    <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_q  <= 1'b0;
            skid_killed_q <= 1'b0;
            skid_data_q   <= BUBBLE_VALUE;
`endif
        end else begin
            valid_q  <= valid_d;
            killed_q <= killed_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_q  <= skid_valid_d;
            skid_killed_q <= skid_killed_d;
            skid_data_q   <= skid_data_d;
`endif
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue-based reference model
module tb_pipe_stage_reg;
    localparam logic [127:0] BV = 128'h13;
    localparam logic [127:0] KM = 128'hFFFF_FFFF_0000_0000;

    logic         clk = 1'b0, rst_sync, flush, up_valid, up_ready, up_kill, dn_valid, dn_ready, dn_killed;
    logic [127:0] up_data, dn_data;
    logic [7:0]   kill_count;

    typedef struct { logic [127:0] d; logic k; } ent_t;
    ent_t         q[$];
    logic [127:0] last;
    int           cnt;
    int           n_chk = 0, n_fail = 0;

    pipe_stage_reg #(.DATA_W(128), .BUBBLE_VALUE(BV), .KEEP_MASK(KM), .CNT_W(8)) dut (
        .clk(clk), .rst_sync(rst_sync), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_kill(up_kill),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .dn_killed(dn_killed),
        .kill_count(kill_count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] bub(input logic [127:0] x);
        return (x & KM) | (BV & ~KM);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || dn_ready;
`endif
    endfunction

    // one clock: drive, compare against model, advance model, then settle after the edge
    task automatic step(input logic r, input logic f, input logic uv, input logic [127:0] ud,
                        input logic uk, input logic dr);
        logic         rdy;
        logic [127:0] shown;
        ent_t         e;
        @(negedge clk);
        rst_sync = r; flush = f; up_valid = uv; up_data = ud; up_kill = uk; dn_ready = dr;
        #1;
        rdy   = model_ready();
        shown = q.size() > 0 ? q[0].d : last;
        check("dn_valid", 128'(dn_valid), 128'(q.size() > 0));
        check("dn_data", dn_data, shown);
        check("dn_killed", 128'(dn_killed), 128'(q.size() > 0 ? q[0].k : 1'b0));
        check("kill_count", 128'(kill_count), 128'(cnt));
        check("up_ready", 128'(up_ready), 128'(rdy));
        if (r) begin
            q.delete(); last = BV; cnt = 0;
        end else if (f) begin
            last = bub(shown); q.delete();
        end else begin
            if (q.size() > 0 && dr) begin
                last = q[0].d;
                void'(q.pop_front());
            end
            if (uv && rdy) begin
                e.d = uk ? bub(ud) : ud;
                e.k = uk;
                q.push_back(e);
                if (uk && cnt < 255) cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        last = BV; cnt = 0;
        rst_sync = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; up_kill = 1'b0; dn_ready = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 128'h99, 1, 1);
        check("rst_valid", 128'(dn_valid), 128'(0));
        check("rst_killed", 128'(dn_killed), 128'(0));
        check("rst_data", dn_data, 128'h13);
        check("rst_count", 128'(kill_count), 128'(0));
        check("rst_ready", 128'(up_ready), 128'(1));

        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 1, 128'(i), 0, 1);
            check("stream_valid", 128'(dn_valid), 128'(1));
            check("stream_data", dn_data, 128'(i));
        end
        step(0, 0, 0, 0, 0, 1);

        step(0, 0, 1, {64'h0, 32'h8000_0040, 32'h0000_0033}, 1, 1);
        check("kill_data", dn_data, {64'h0, 32'h8000_0040, 32'h13});
        check("kill_flag", 128'(dn_killed), 128'(1));
        check("kill_cnt1", 128'(kill_count), 128'(1));
        step(0, 0, 0, 0, 0, 1);

        step(0, 0, 1, 128'hAB, 0, 0);
        step(0, 0, 1, 128'hCD, 0, 0);
        check("stall_ready", 128'(up_ready), 128'(0));
        check("stall_data", dn_data, 128'hAB);
        step(0, 0, 0, 0, 0, 1);
`ifdef PIPE_STAGE_SKID_EN
        check("skid_second", dn_data, 128'hCD);
        step(0, 0, 0, 0, 0, 1);
`endif
        check("drain_valid", 128'(dn_valid), 128'(0));

        step(0, 0, 1, 128'h1234_5678_0000_0055, 0, 1);
        step(0, 1, 1, 128'h77, 0, 1);
        check("flush_valid", 128'(dn_valid), 128'(0));
        check("flush_data", dn_data, 128'h1234_5678_0000_0013);
        check("flush_ready", 128'(up_ready), 128'(1));
        step(0, 0, 0, 0, 0, 1);
        check("flush_no77", 128'(dn_valid), 128'(0));

        for (int i = 0; i < 300; i++) step(0, 0, 1, 128'(i), 1, 1);
        check("sat_count", 128'(kill_count), 128'(255));
        step(0, 0, 1, 128'h5, 1, 1);
        check("sat_hold", 128'(kill_count), 128'(255));

        for (int i = 0; i < 3000; i++)
            step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(3) == 0,
                 $urandom_range(2) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
